// File: rtl/multicycle_mainfsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_mainfsm_if
// Control bundle between the multicycle main FSM and the datapath.
//   slave  : the FSM side (consumes decode/flag inputs, drives strobes/selects)
//   master : the datapath/environment side
// Signals:
//   op[6:0], funct3[2:0]      instruction fields from IR
//   Zero, Lt                  ALU flags
//   MemReady                  memory access completes this cycle
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc[1:0],
//   ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0]   datapath controls
//   InstrDone                 final-cycle pulse
//   Illegal                   sticky unsupported-opcode flag
//   State[3:0]                current state (debug)
// -----------------------------------------------------------------------------
interface multicycle_mainfsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       Lt;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       InstrDone;
    logic       Illegal;
    logic [3:0] State;

    modport slave (
        input  op, funct3, Zero, Lt, MemReady,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, State
    );

    modport master (
        output op, funct3, Zero, Lt, MemReady,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, State
    );
endinterface

// File: rtl/multicycle_mainfsm.sv
// -----------------------------------------------------------------------------
// multicycle_mainfsm
// Main control FSM of the multicycle RV32I core. Steps each instruction
// through its state sequence and drives the shared-datapath selects and
// write strobes, including the branch-qualified PCWrite.
// Ports:
//   clk    core clock
//   reset  asynchronous, active-high reset
//   bus    multicycle_mainfsm_if.slave (decode inputs, flags, MemReady,
//          all datapath controls, InstrDone, Illegal, State)
// Parameters:
//   HAS_MEM_READY  1: MemReady honoured; 0: MemReady treated as always 1
// -----------------------------------------------------------------------------
module multicycle_mainfsm #(
    parameter bit HAS_MEM_READY = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_mainfsm_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        ILLEGAL  = 4'd13
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;
    logic   mem_rdy;
    logic   taken;

    logic       pc_write, ir_write, mem_write, reg_write, instr_done;
    logic       adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    assign mem_rdy = HAS_MEM_READY ? bus.MemReady : 1'b1;

    // Branch condition; unsupported funct3 values simply fall through.
    always_comb begin
        case (bus.funct3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.Lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    7'b0000011,
                    7'b0100011: state_d = MEMADR;
                    7'b0110011: state_d = EXECR;
                    7'b0010011: state_d = EXECI;
                    7'b1100011: state_d = BRANCH;
                    7'b1101111: state_d = JAL;
                    7'b1100111: state_d = JALR;
                    7'b0110111: state_d = LUI;
                    default:    state_d = ILLEGAL;
                endcase
            end
            // op[5] separates sw (0100011) from lw (0000011).
            MEMADR:   state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_rdy ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_rdy ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JALR:     state_d = JAL;
            JAL:      state_d = ALUWB;
            LUI:      state_d = FETCH;
            ILLEGAL:  state_d = ILLEGAL;
            default:  state_d = FETCH;
        endcase
    end

    // Illegal is set on the transition into ILLEGAL so it is already high
    // in the first ILLEGAL cycle; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_rdy;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                instr_done = 1'b1;
                pc_write   = taken;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            // PC takes the target held in ALUOut while OldPC+4 is computed
            // for the link write in ALUWB.
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing writes while reset is high,
    // including the instant it rises mid-instruction.
    assign bus.PCWrite   = pc_write   & ~reset;
    assign bus.IRWrite   = ir_write   & ~reset;
    assign bus.MemWrite  = mem_write  & ~reset;
    assign bus.RegWrite  = reg_write  & ~reset;
    assign bus.InstrDone = instr_done & ~reset;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.Illegal   = illegal_q;
    assign bus.State     = state_q;

endmodule
